// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Bundles the redirect, instruction-memory and decode
//                handshakes of the fetch stage. The master modport is the
//                fetch stage; the slave modport is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
   // Redirect from Branch_calc
   logic        Branch;
   logic [31:0] BrPC;
   // Instruction memory request/grant/response
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   // Decode valid/ready
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        id_ready;

   modport master (
      input  Branch, BrPC, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      output imem_req, imem_addr, id_valid, id_inst, id_pc
   );

   modport slave (
      output Branch, BrPC, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      input  imem_req, imem_addr, id_valid, id_inst, id_pc
   );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Owns the PC, issues one outstanding
//                word read at a time, buffers responses in a small FIFO and
//                hands {pc, inst} to decode. A Branch redirect reloads the
//                PC, flushes the buffer and drops any in-flight response.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   fetch_stage_if.master fif
);

   localparam int PW = $clog2(DEPTH);

   localparam logic [PW:0]   c_FULL    = DEPTH[PW:0];
   localparam logic [PW:0]   c_CNT_ONE = 1;
   localparam logic [PW-1:0] c_PTR_ONE = 1;
   localparam logic [31:0]   c_PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t        r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_tag;

   logic [PW:0]   r_count;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [31:0]   r_inst_mem [DEPTH];
   logic [31:0]   r_pc_mem   [DEPTH];

   logic          w_req;
   logic          w_grant;
   logic          w_push;
   logic          w_pop;
   logic          w_valid;

   // rst_n gates the request so it drops the instant reset asserts and rises
   // in the very first cycle after release, without waiting for an edge.
   assign w_req   = rst_n && (r_state == S_REQ) && (r_count != c_FULL);
   // A grant coinciding with Branch is not an acceptance.
   assign w_grant = w_req && fif.imem_gnt && !fif.Branch;
   assign w_push  = (r_state == S_WAIT) && fif.imem_rvalid && !fif.Branch;
   assign w_valid = (r_count != '0);
   // Decode treats Branch as a flush of its own input, so no transfer.
   assign w_pop   = w_valid && fif.id_ready && !fif.Branch;

   assign fif.imem_req  = w_req;
   assign fif.imem_addr = r_pc;
   assign fif.id_valid  = w_valid;
   assign fif.id_inst   = w_valid ? r_inst_mem[r_rd_ptr] : '0;
   assign fif.id_pc     = w_valid ? r_pc_mem[r_rd_ptr]   : '0;

   // Fetch FSM: PC update, request tagging and redirect handling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
         r_tag   <= '0;
      end else if (fif.Branch) begin
         // Redirect wins; a pending response must be drained before refetch.
         r_pc <= fif.BrPC & 32'hFFFF_FFFC;
         case (r_state)
            S_REQ:   r_state <= S_REQ;
            S_WAIT:  r_state <= fif.imem_rvalid ? S_REQ : S_DROP;
            S_DROP:  r_state <= fif.imem_rvalid ? S_REQ : S_DROP;
            default: r_state <= S_REQ;
         endcase
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_grant) begin
                  r_pc    <= r_pc + c_PC_STEP;
                  r_tag   <= r_pc;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (fif.imem_rvalid) begin
                  r_state <= S_REQ;
               end
            end
            S_DROP: begin
               if (fif.imem_rvalid) begin
                  r_state <= S_REQ;
               end
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

   // Buffer pointers and occupancy; a redirect empties the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (fif.Branch) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CNT_ONE;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - c_CNT_ONE;
         end
      end
   end

   // Buffer storage; contents are only visible while occupancy is non-zero.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_inst_mem[r_wr_ptr] <= fif.imem_rdata;
         r_pc_mem[r_wr_ptr]   <= r_tag;
      end
   end

endmodule
`default_nettype wire
